// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory load controller.
package imem_load_ctrl_pkg;

    localparam int DEPTH_DEF = 2048;
    localparam int AW_DEF    = 11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader, fetch and imem write-port signals of the load controller.
interface imem_load_ctrl_if
    import imem_load_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic          load_start_i;
    logic          load_valid_i;
    logic [31:0]   load_data_i;
    logic          load_last_i;
    logic          load_ready_o;
    logic [31:0]   fetch_addr_i;
    logic          fetch_stall_o;
    logic          cpu_rst_no;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_we_o;
    logic [AW:0]   word_cnt_o;
    logic          done_o;
    logic          err_o;

    modport slave (
        input  load_start_i, load_valid_i, load_data_i, load_last_i, fetch_addr_i,
        output load_ready_o, fetch_stall_o, cpu_rst_no, mem_addr_o, mem_wdata_o,
               mem_we_o, word_cnt_o, done_o, err_o
    );

    modport master (
        output load_start_i, load_valid_i, load_data_i, load_last_i, fetch_addr_i,
        input  load_ready_o, fetch_stall_o, cpu_rst_no, mem_addr_o, mem_wdata_o,
               mem_we_o, word_cnt_o, done_o, err_o
    );

endinterface

// File: rtl/imem_load_ctrl.sv
// Streams a program into imem while holding the core in reset, then hands
// the memory port back to instruction fetch.
//
// state    | meaning
// ST_RUN   | core runs, fetch owns the imem address
// ST_LOAD  | loader words are written at consecutive addresses
// ST_FLUSH | single cycle after the final word, core still held
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    imem_load_ctrl_if.slave  bus
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_t      r_state;
    state_t      w_next;
    logic [AW:0] r_cnt;
    logic        r_err;
    logic        r_done;
    logic        r_cpu_rst_n;
    logic        w_accept;
    logic        w_overflow;
    logic        w_unused;

    assign w_unused = ^{bus.fetch_addr_i[31:AW+2], bus.fetch_addr_i[1:0]};

    always_comb begin
        w_next            = r_state;
        w_accept          = 1'b0;
        w_overflow        = 1'b0;
        bus.load_ready_o  = 1'b0;
        bus.fetch_stall_o = 1'b0;
        bus.mem_we_o      = 1'b0;
        bus.mem_addr_o    = bus.fetch_addr_i[AW+1:2];
        bus.mem_wdata_o   = bus.load_data_i;
        case (r_state)
            ST_RUN: begin
                if (bus.load_start_i) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                bus.load_ready_o  = 1'b1;
                bus.fetch_stall_o = 1'b1;
                bus.mem_addr_o    = r_cnt[AW-1:0];
                w_accept          = bus.load_valid_i;
                bus.mem_we_o      = bus.load_valid_i;
                if (w_accept) begin
                    if (bus.load_last_i) begin
                        w_next = ST_FLUSH;
                    end else if (r_cnt == LAST_IDX) begin
                        // memory full without a last marker: stop rather than wrap
                        w_next     = ST_FLUSH;
                        w_overflow = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                bus.fetch_stall_o = 1'b1;
                w_next            = ST_RUN;
            end
            default: w_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= (r_state == ST_FLUSH);
            r_cpu_rst_n <= (w_next == ST_RUN);
            if (r_state == ST_RUN && bus.load_start_i) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_overflow) r_err <= 1'b1;
        end
    end

    assign bus.cpu_rst_no = r_cpu_rst_n;
    assign bus.word_cnt_o = r_cnt;
    assign bus.done_o     = r_done;
    assign bus.err_o      = r_err;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed and randomized bench for imem_load_ctrl; a write log is compared
// against the expected program image for every load.
module tb_imem_load_ctrl;
    import imem_load_ctrl_pkg::*;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    imem_load_ctrl_if #(.AW(AW)) bus ();

    imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    wr_t         wr_q[$];
    logic [31:0] data_src[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk_i)
        if (bus.mem_we_o === 1'b1) wr_q.push_back({bus.mem_addr_o, bus.mem_wdata_o});

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Start a load, stream n words (optionally with gaps), and verify the
    // FLUSH cycle, done pulse and the exact image written to memory.
    task automatic run_load(input int n, input bit set_last, input bit toggle_valid,
                            input bit hold_start);
        logic [31:0] exp_data[$];
        int          base;
        int          k       = 0;
        int          c       = 0;
        bit          ended   = 1'b0;
        bit          exp_err = 1'b0;
        bit          last_now;
        logic [31:0] d;
        logic [31:0] fa;

        bus.load_start_i = 1'b1;
        cycle();
        if (!hold_start) bus.load_start_i = 1'b0;
        #1;
        check("ld_ready",   32'(bus.load_ready_o), 32'd1);
        check("ld_cpu_rst", 32'(bus.cpu_rst_no),   32'd0);
        check("ld_stall",   32'(bus.fetch_stall_o), 32'd1);
        check("ld_cnt0",    32'(bus.word_cnt_o),   32'd0);
        check("ld_err0",    32'(bus.err_o),        32'd0);
        base = wr_q.size();

        while (!ended) begin
            if (toggle_valid && (c % 2 == 1)) begin
                bus.load_valid_i = 1'b0;
                bus.load_last_i  = 1'b1;
                #1;
                check("idle_we", 32'(bus.mem_we_o), 32'd0);
            end else begin
                d = (data_src.size() > 0) ? data_src.pop_front() : $urandom;
                last_now         = set_last && (k == n - 1);
                bus.load_valid_i = 1'b1;
                bus.load_data_i  = d;
                bus.load_last_i  = last_now;
                #1;
                check("beat_we",    32'(bus.mem_we_o),    32'd1);
                check("beat_addr",  32'(bus.mem_addr_o),  32'(k));
                check("beat_wdata", bus.mem_wdata_o,      d);
                check("beat_cnt",   32'(bus.word_cnt_o),  32'(k));
                exp_data.push_back(d);
                if (k == DEPTH - 1 && !last_now) exp_err = 1'b1;
                k++;
                ended = last_now || (k == DEPTH);
            end
            c++;
            cycle();
        end

        bus.load_valid_i = 1'b1;
        bus.load_last_i  = 1'b0;
        bus.load_data_i  = $urandom;
        #1;
        check("fl_ready",   32'(bus.load_ready_o),  32'd0);
        check("fl_we",      32'(bus.mem_we_o),      32'd0);
        check("fl_stall",   32'(bus.fetch_stall_o), 32'd1);
        check("fl_cpu_rst", 32'(bus.cpu_rst_no),    32'd0);
        check("fl_done",    32'(bus.done_o),        32'd0);
        check("fl_err",     32'(bus.err_o),         32'(exp_err));
        cycle();
        bus.load_valid_i = 1'b0;
        fa = $urandom;
        bus.fetch_addr_i = fa;
        #1;
        check("dn_done",    32'(bus.done_o),        32'd1);
        check("dn_cpu_rst", 32'(bus.cpu_rst_no),    32'd1);
        check("dn_stall",   32'(bus.fetch_stall_o), 32'd0);
        check("dn_cnt",     32'(bus.word_cnt_o),    32'(k));
        check("dn_err",     32'(bus.err_o),         32'(exp_err));
        check("dn_addr",    32'(bus.mem_addr_o),    32'(fa[AW+1:2]));

        check("img_size", 32'(wr_q.size()), 32'(base + k));
        for (int i = 0; i < k && base + i < wr_q.size(); i++) begin
            check("img_addr", 32'(wr_q[base+i].addr), 32'(i));
            check("img_data", wr_q[base+i].data, exp_data[i]);
        end

        if (!hold_start) begin
            cycle();
            #1;
            check("post_done", 32'(bus.done_o),     32'd0);
            check("post_cnt",  32'(bus.word_cnt_o), 32'(k));
            check("post_err",  32'(bus.err_o),      32'(exp_err));
        end
    endtask

    initial begin
        int          base;
        logic [31:0] fa;

        bus.load_start_i = 1'b1;
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 32'hDEAD_BEEF;
        bus.load_last_i  = 1'b0;
        bus.fetch_addr_i = 32'h0000_0010;
        cycle();
        cycle();
        #1;
        check("rst_cpu_rst", 32'(bus.cpu_rst_no),   32'd0);
        check("rst_done",    32'(bus.done_o),       32'd0);
        check("rst_err",     32'(bus.err_o),        32'd0);
        check("rst_cnt",     32'(bus.word_cnt_o),   32'd0);
        check("rst_we",      32'(bus.mem_we_o),     32'd0);
        check("rst_ready",   32'(bus.load_ready_o), 32'd0);

        bus.load_start_i = 1'b0;
        bus.load_valid_i = 1'b0;
        rst_ni           = 1'b1;
        #1;
        check("rel_cpu_rst_pre", 32'(bus.cpu_rst_no), 32'd0);
        @(negedge clk_i);
        #1;
        check("rel_cpu_rst", 32'(bus.cpu_rst_no),    32'd1);
        check("rel_stall",   32'(bus.fetch_stall_o), 32'd0);
        check("rel_addr",    32'(bus.mem_addr_o),    32'd4);

        // fetch addressing in RUN; stray valids must not write
        for (int i = 0; i < 8; i++) begin
            fa = $urandom;
            bus.fetch_addr_i = fa;
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = $urandom;
            #1;
            check("run_addr",  32'(bus.mem_addr_o),   32'(fa[AW+1:2]));
            check("run_we",    32'(bus.mem_we_o),     32'd0);
            check("run_ready", 32'(bus.load_ready_o), 32'd0);
            cycle();
        end
        bus.load_valid_i = 1'b0;
        check("run_nowrite", 32'(wr_q.size()), 32'd0);

        data_src = '{32'h00D0_0793, 32'h0387_C713, 32'h00E7_E713};
        run_load(3, 1'b1, 1'b0, 1'b0);
        run_load(6, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_load(int'($urandom_range(1, 12)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);

        run_load(4, 1'b1, 1'b0, 1'b1);
        run_load(2, 1'b1, 1'b0, 1'b0);

        run_load(DEPTH, 1'b0, 1'b0, 1'b0);
        run_load(2, 1'b1, 1'b0, 1'b0);
        run_load(DEPTH, 1'b1, 1'b0, 1'b0);

        // reset in the middle of a load
        bus.load_start_i = 1'b1;
        cycle();
        bus.load_start_i = 1'b0;
        base = wr_q.size();
        for (int i = 0; i < 5; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_last_i  = 1'b0;
            bus.load_data_i  = $urandom;
            cycle();
        end
        check("mr_writes", 32'(wr_q.size()), 32'(base + 5));
        check("mr_cnt5",   32'(bus.word_cnt_o), 32'd5);
        rst_ni = 1'b0;
        #1;
        check("mr_we",      32'(bus.mem_we_o),      32'd0);
        check("mr_ready",   32'(bus.load_ready_o),  32'd0);
        check("mr_stall",   32'(bus.fetch_stall_o), 32'd0);
        check("mr_cpu_rst", 32'(bus.cpu_rst_no),    32'd0);
        check("mr_cnt",     32'(bus.word_cnt_o),    32'd0);
        base = wr_q.size();
        cycle();
        cycle();
        check("mr_nowrite", 32'(wr_q.size()), 32'(base));
        rst_ni = 1'b1;
        #1;
        check("mr_cpu_rst_pre", 32'(bus.cpu_rst_no), 32'd0);
        @(negedge clk_i);
        #1;
        check("mr_cpu_rst_rel", 32'(bus.cpu_rst_no),    32'd1);
        check("mr_stall_rel",   32'(bus.fetch_stall_o), 32'd0);
        cycle();
        check("mr_nowrite_rel", 32'(wr_q.size()), 32'(base));
        bus.load_valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
